// File: rtl/ibex_cap_regfile_clr.sv
// Capability register file: two write ports, optional write-through reads,
// and a sequential masked-clear engine that nulls selected registers.
module ibex_cap_regfile_clr #(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 93,
  parameter logic [DataWidth-1:0] ResetValue   = 93'h000000000000001F690003F0,
  parameter logic [DataWidth-1:0] ZeroValue    = 93'h000000000000001F690003F0,
  parameter bit                   WriteThrough = 1'b0,
  localparam int unsigned         NumWords     = RV32E ? 16 : 32,
  localparam int unsigned         AddrWidth    = RV32E ? 4 : 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_en_i,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  input  logic [4:0]           waddr_b_i,
  input  logic [DataWidth-1:0] wdata_b_i,
  input  logic                 we_b_i,
  input  logic                 clr_req_i,
  input  logic [NumWords-1:0]  clr_mask_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o
);

  typedef enum logic [1:0] {
    ClrIdle,
    ClrRun,
    ClrDone
  } clr_state_e;

  clr_state_e state_q, state_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic [NumWords-1:0]  mask_q, mask_d;
  logic                 clr_we;

  logic [DataWidth-1:0] rf_q   [1:NumWords-1];
  logic [DataWidth-1:0] rf_d   [1:NumWords-1];
  logic [DataWidth-1:0] rd_src [1:NumWords-1];

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ClrIdle;
      idx_q   <= AddrWidth'(1);
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    unique case (state_q)
      ClrIdle: begin
        if (clr_req_i) begin
          state_d = ClrRun;
          idx_d   = AddrWidth'(1);
          mask_d  = clr_mask_i;
        end
      end
      ClrRun: begin
        if (idx_q == AddrWidth'(NumWords - 1)) begin
          state_d = ClrDone;
        end else begin
          idx_d = idx_q + AddrWidth'(1);
        end
      end
      ClrDone: state_d = ClrIdle;
      default: state_d = ClrIdle;
    endcase
  end

  always_comb begin
    clr_busy_o = (state_q != ClrIdle);
    clr_done_o = (state_q == ClrDone);
    clr_we     = (state_q == ClrRun) && mask_q[idx_q];
  end

  // Later assignments win: clear engine over port B over port A.
  always_comb begin
    for (int i = 1; i < NumWords; i++) begin
      rf_d[i] = rf_q[i];
      if (we_a_i && waddr_a_i == 5'(i)) rf_d[i] = wdata_a_i;
      if (we_b_i && waddr_b_i == 5'(i)) rf_d[i] = wdata_b_i;
      if (clr_we && idx_q == AddrWidth'(i)) rf_d[i] = ResetValue;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumWords; i++) rf_q[i] <= ResetValue;
    end else begin
      for (int i = 1; i < NumWords; i++) rf_q[i] <= rf_d[i];
    end
  end

  always_comb begin
    for (int i = 1; i < NumWords; i++) begin
      rd_src[i] = WriteThrough ? rf_d[i] : rf_q[i];
    end
  end

  // x0 and out-of-range addresses match no entry and fall back to ZeroValue.
  always_comb begin
    rdata_a_o = ZeroValue;
    rdata_b_o = ZeroValue;
    for (int i = 1; i < NumWords; i++) begin
      if (raddr_a_i == 5'(i)) rdata_a_o = rd_src[i];
      if (raddr_b_i == 5'(i)) rdata_b_o = rd_src[i];
    end
  end

endmodule

// File: tb/tb_ibex_cap_regfile_clr.sv
// Directed bench for ibex_cap_regfile_clr: default, write-through
// and RV32E instances driven from shared write/read stimulus.
module tb_ibex_cap_regfile_clr;

  localparam logic [92:0] RV = 93'h000000000000001F690003F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_en = 1'b0;
  logic [4:0]  raddr_a = '0, raddr_b = '0;
  logic [4:0]  waddr_a = '0, waddr_b = '0;
  logic [92:0] wdata_a = '0, wdata_b = '0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic        clr_req = 1'b0, clr_req_e = 1'b0;
  logic [31:0] clr_mask = '0;
  logic [15:0] clr_mask_e = '0;

  logic [92:0] d_rda, d_rdb, w_rda, w_rdb, e_rda, e_rdb;
  logic        d_busy, d_done, w_busy, w_done, e_busy, e_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ibex_cap_regfile_clr u_d (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_a_i(raddr_a), .rdata_a_o(d_rda),
    .raddr_b_i(raddr_b), .rdata_b_o(d_rdb),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .clr_req_i(clr_req), .clr_mask_i(clr_mask),
    .clr_busy_o(d_busy), .clr_done_o(d_done)
  );

  ibex_cap_regfile_clr #(.WriteThrough(1'b1)) u_w (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_a_i(raddr_a), .rdata_a_o(w_rda),
    .raddr_b_i(raddr_b), .rdata_b_o(w_rdb),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .clr_req_i(clr_req), .clr_mask_i(clr_mask),
    .clr_busy_o(w_busy), .clr_done_o(w_done)
  );

  ibex_cap_regfile_clr #(.RV32E(1'b1)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_a_i(raddr_a), .rdata_a_o(e_rda),
    .raddr_b_i(raddr_b), .rdata_b_o(e_rdb),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .clr_req_i(clr_req_e), .clr_mask_i(clr_mask_e),
    .clr_busy_o(e_busy), .clr_done_o(e_done)
  );

  task automatic chk(input string tag, input logic [92:0] got,
                     input logic [92:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bc, dc, dk;
    logic [92:0] exp;

    // Reset state
    #2;
    chk("rst_busy", {92'd0, d_busy}, 93'd0);
    chk("rst_done", {92'd0, d_done}, 93'd0);
    chk("rst_e_busy", {92'd0, e_busy}, 93'd0);
    #10;
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      raddr_a = 5'(a);
      raddr_b = 5'(31 - a);
      #1;
      chk("rst_rda", d_rda, RV);
      chk("rst_rdb", d_rdb, RV);
      chk("rst_e_rda", e_rda, RV);
    end
    chk("rst_busy2", {92'd0, d_busy}, 93'd0);
    chk("rst_done2", {92'd0, d_done}, 93'd0);

    // Dual write to x5: B wins
    we_a = 1; we_b = 1; waddr_a = 5; waddr_b = 5;
    wdata_a = 93'h1; wdata_b = 93'h2; raddr_a = 5;
    #1;
    chk("wt_dual_same_cycle", w_rda, 93'h2);
    chk("nowt_dual_old", d_rda, RV);
    tick();
    we_a = 0; we_b = 0;
    #1;
    chk("dual_b_wins", d_rda, 93'h2);

    // Write to x0 dropped
    we_a = 1; waddr_a = 0; wdata_a = 93'hABC; raddr_a = 0;
    tick();
    we_a = 0;
    #1;
    chk("x0_read", d_rda, RV);
    chk("x0_read_wt", w_rda, RV);

    // x17 out of range on RV32E
    we_a = 1; waddr_a = 17; wdata_a = 93'h123;
    tick();
    we_a = 0; raddr_a = 17; raddr_b = 1;
    #1;
    chk("e_x17_zero", e_rda, RV);
    chk("d_x17_written", d_rda, 93'h123);
    chk("e_x1_untouched", e_rdb, RV);

    // Write-through vs registered read on x7
    we_a = 1; waddr_a = 7; wdata_a = 93'h55; raddr_a = 7;
    #1;
    chk("wt_same_cycle", w_rda, 93'h55);
    chk("nowt_old_value", d_rda, RV);
    tick();
    we_a = 0;
    #1;
    chk("nowt_next_cycle", d_rda, 93'h55);

    // Fill x1..x31 with index values
    for (int i = 1; i < 32; i++) begin
      we_a = 1; waddr_a = 5'(i); wdata_a = 93'(i);
      tick();
    end
    we_a = 0;

    // Masked clear 0xAA; mask change mid-clear must be ignored
    clr_req = 1; clr_mask = 32'h0000_00AA;
    tick();
    clr_req = 0;
    bc = 0; dc = 0; dk = 0;
    for (int k = 1; k <= 36; k++) begin
      if (d_busy) bc++;
      if (d_done) begin dc++; dk = k; end
      if (k == 2) clr_mask = 32'hFFFF_FFFF;
      tick();
    end
    chk("mclr_busy_cycles", 93'(bc), 93'd32);
    chk("mclr_done_cycle", 93'(dk), 93'd32);
    chk("mclr_done_count", 93'(dc), 93'd1);
    for (int i = 1; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(i);
      exp = (i == 1 || i == 3 || i == 5 || i == 7) ? RV : 93'(i);
      #1;
      chk("mclr_reg", d_rda, exp);
      chk("mclr_reg_wt", w_rdb, exp);
    end

    // Collision at x20 with all-ones mask; request during busy ignored
    clr_req = 1; clr_mask = 32'hFFFF_FFFF;
    tick();
    clr_req = 0;
    bc = 0; dc = 0; dk = 0;
    raddr_a = 20;
    for (int k = 1; k <= 40; k++) begin
      if (d_busy) bc++;
      if (d_done) begin dc++; dk = k; end
      we_a = (k == 20 || k == 21);
      waddr_a = 20;
      wdata_a = (k == 20) ? 93'h777 : 93'h888;
      clr_req = (k == 20 || k == 21);
      #1;
      if (k == 20) chk("wt_clr_beats_a", w_rda, RV);
      if (k == 21) chk("clr_wr_x20", d_rda, RV);
      tick();
    end
    we_a = 0; clr_req = 0;
    #1;
    chk("coll_busy_cycles", 93'(bc), 93'd32);
    chk("coll_done_cycle", 93'(dk), 93'd32);
    chk("coll_done_count", 93'(dc), 93'd1);
    chk("coll_x20_persist", d_rda, 93'h888);
    raddr_b = 31;
    #1;
    chk("coll_x31_cleared", d_rdb, RV);

    // RV32E clear length
    raddr_a = 9;
    #1;
    chk("e_x9_before", e_rda, 93'd9);
    clr_req_e = 1; clr_mask_e = 16'hFFFF;
    tick();
    clr_req_e = 0;
    bc = 0; dc = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      if (e_busy) bc++;
      if (e_done) begin dc++; dk = k; end
      tick();
    end
    chk("e_busy_cycles", 93'(bc), 93'd16);
    chk("e_done_cycle", 93'(dk), 93'd16);
    chk("e_done_count", 93'(dc), 93'd1);
    chk("e_x9_cleared", e_rda, RV);

    // Reset mid-clear aborts with no done pulse
    we_a = 1; waddr_a = 3; wdata_a = 93'h33; raddr_a = 3; raddr_b = 20;
    tick();
    we_a = 0;
    #1;
    chk("e_x3_written", e_rda, 93'h33);
    clr_req_e = 1; clr_mask_e = 16'h0000;
    tick();
    clr_req_e = 0;
    tick();
    tick();
    chk("e_busy_mid", {92'd0, e_busy}, 93'd1);
    rst_n = 0;
    #1;
    chk("e_busy_after_rst", {92'd0, e_busy}, 93'd0);
    chk("e_done_after_rst", {92'd0, e_done}, 93'd0);
    chk("e_x3_reset", e_rda, RV);
    chk("d_x20_reset", d_rdb, RV);
    tick();
    tick();
    rst_n = 1;
    dc = 0; bc = 0;
    for (int k = 0; k < 20; k++) begin
      if (e_done) dc++;
      if (e_busy) bc++;
      tick();
    end
    chk("e_no_done_after_abort", 93'(dc), 93'd0);
    chk("e_idle_after_abort", 93'(bc), 93'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ibex_cap_regfile_clr.md
# ibex_cap_regfile_clr

Parametrised flip-flop capability register file for the CHERI-extended ibex core, with two write ports, optional write-through read bypass and a sequential masked-clear engine. It replaces the single-write-port register file between decode (read ports) and writeback/load-store (write ports). The clear engine resets a selected subset of registers to the null capability on compartment switches without stalling the read ports.

## Interface
- RV32E, 0, 1 selects 16 registers (ADDR_WIDTH=4), 0 selects 32 registers (ADDR_WIDTH=5)
- DataWidth, 93, capability width in bits
- ResetValue, 93'h000000000000001F690003F0, value loaded by reset and by the clear engine (null capability)
- ZeroValue, 93'h000000000000001F690003F0, value always read from x0
- WriteThrough, 0, 1 makes reads return same-cycle write data on address match
- clk_i  input  1  clock; all state on rising edge
- rst_ni  input  1  reset: asynchronous, active-low
- test_en_i  input  1  test enable, functionally unused
- raddr_a_i / raddr_b_i  input  5  read addresses
- rdata_a_o / rdata_b_o  output  DataWidth  read data, combinational
- waddr_a_i, wdata_a_i, we_a_i  input  5 / DataWidth / 1  write port A
- waddr_b_i, wdata_b_i, we_b_i  input  5 / DataWidth / 1  write port B
- clr_req_i  input  1  start masked clear (sampled only in IDLE)
- clr_mask_i  input  NUM_WORDS  bit i set: clear register i; bit 0 ignored
- clr_busy_o  output  1  clear engine active
- clr_done_o  output  1  one-cycle pulse when clear completes

## Operation
- Storage:
  - Registers 1..NUM_WORDS-1 are DataWidth flops.
  - Register 0 is not stored; reads of x0 return ZeroValue; writes to x0 are dropped.
- RV32E=1: addresses with bit 4 set are out of range. Writes to them are dropped; reads return ZeroValue.
- Write priority per register, per edge: clear engine > port B > port A.
  - Ports A and B to the same address in the same cycle: B's data is stored.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: if clr_req_i=1, latch clr_mask_i into mask_q, set idx_q=1, go to CLEAR.
  - CLEAR: each cycle, if mask_q[idx_q]=1, write ResetValue to register idx_q. If idx_q=NUM_WORDS-1, go to DONE; otherwise increment idx_q.
  - DONE: clr_done_o=1 for this cycle only, then go to IDLE.
- clr_busy_o=1 in CLEAR and DONE.
- clr_req_i outside IDLE is ignored, with no queuing.
- Mask changes after the latching cycle have no effect.
- Port writes during CLEAR:
  - To an already-visited index: persist.
  - To a not-yet-visited masked index: overwritten when the engine reaches it.
  - To an unmasked index: persist.
- WriteThrough=1: each read port returns the value that will be stored in its addressed register at the next edge, using the same priority. Otherwise it returns stored contents. x0 and out-of-range addresses still read ZeroValue.
- WriteThrough=0: reads return stored contents only.

## Timing
- Reset: all registers = ResetValue, FSM = IDLE, idx_q = 1, mask_q = 0, clr_busy_o = 0, clr_done_o = 0.
  - Reset mid-clear aborts immediately; no done pulse is produced.
- Write latency: data is visible on read ports the cycle after the write edge (WriteThrough=0), or the same cycle (WriteThrough=1).
- Read ports are combinational from raddr to rdata; there are no read-enable ports.
- Clear latency, measured from the edge that samples clr_req_i:
  - CLEAR lasts NUM_WORDS-1 cycles (31, or 15 with RV32E).
  - DONE lasts 1 cycle.
  - clr_busy_o is high for NUM_WORDS cycles in total.
- A new request may be sampled in the cycle after DONE.
- idx_q is ADDR_WIDTH bits and does not wrap; it terminates at NUM_WORDS-1.

## Test plan
- Reset, then read all 32 addresses with no writes: every address returns 93'h…1F690003F0, and clr_busy_o=0, clr_done_o=0.
- Same-cycle dual write: we_a/we_b=1, waddr_a=waddr_b=5, wdata_a=0x1, wdata_b=0x2. Next cycle x5 reads 0x2. A write to x0 with 0xABC reads back ZeroValue.
- Masked clear: write x1..x31 = index value, then pulse clr_req_i with mask=0x0000_00AA.
  - clr_busy_o is high for 32 cycles; clr_done_o pulses in cycle 32.
  - Afterwards x1, x3, x5, x7 = ResetValue; all other registers keep their index value.
- Clear collision: during CLEAR with mask=all ones, write port A to x20 in the same cycle idx_q=20. x20 = ResetValue.
  - A write to x20 one cycle later persists.
  - clr_req_i asserted during busy starts no second clear.
- WriteThrough=1: we_a=1, waddr_a=7, wdata=0x55, raddr_a=7. rdata_a_o=0x55 in the same cycle. With WriteThrough=0 the read shows the old value until the next cycle.
- RV32E=1: clear lasts 15+1 cycles. A write to x17 is dropped and x17 reads ZeroValue. rst_ni low mid-clear gives clr_busy_o=0 immediately, all registers = ResetValue, and no clr_done_o.
